axi_lite_reg_slave: RTL
=======================

# axi_lite_reg_slave

AXI4-Lite responder exposing NUM_REGS 32-bit read/write control registers to the PS master. It is the register-file end of the interface the I2S controller's AXI4-Lite master drives: it accepts single-beat writes and reads, returns OKAY for in-range accesses and SLVERR otherwise, and presents register contents plus per-register write pulses to downstream logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 6: byte-address width of the local window.
- NUM_REGS, 4: register count, 1..16; occupies offsets 0x0..4*NUM_REGS-4.
- RESET_VALUE, 32'h0: reset content of every register.

- ACLK  in  1  sole clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- regs_o  out  32*NUM_REGS  register contents, reg k at bits [32k+31:32k].
- wr_pulse_o  out  NUM_REGS  one-cycle strobe, bit k high the cycle after reg k is written.

## Operation
- Decode: index = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] ignored. index < NUM_REGS -> OKAY (2'b00); else SLVERR (2'b10).
- Write FSM states: WR_IDLE (AWREADY=1, WREADY=1), WR_WAIT_W (AWREADY=0, WREADY=1), WR_WAIT_A (AWREADY=1, WREADY=0), WR_COMMIT (both 0), WR_RESP (both 0, BVALID=1).
  - WR_IDLE: AW and W handshake same edge -> latch both, WR_COMMIT; AW only -> WR_WAIT_W; W only -> WR_WAIT_A.
  - WR_WAIT_W/WR_WAIT_A: missing handshake -> latch, WR_COMMIT.
  - WR_COMMIT -> WR_RESP unconditionally; at that edge in-range register updated per WSTRB lane (unstrobed bytes keep old value), wr_pulse_o bit set, BRESP loaded.
  - WR_RESP: BVALID, BRESP stable until BREADY; on handshake -> WR_IDLE.
- Out-of-range write: no register change, no pulse, BRESP=SLVERR.
- Read FSM states: RD_IDLE (ARREADY=1), RD_DATA (ARREADY=0, RVALID=1). ARVALID handshake -> RDATA/RRESP loaded from register contents as held before that edge, RD_DATA. RRESP handshake -> RD_IDLE. Out-of-range read: RDATA=0, RRESP=SLVERR.
- Read and write FSMs independent; may be active concurrently.

## Timing
- Reset (async assert): all registers = RESET_VALUE; AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse_o = 0; BRESP, RRESP, RDATA = 0; FSMs to idle. Readies are registered: first rise on first ACLK edge after ARESET deasserts.
- Reset mid-transaction: in-flight access abandoned, no partial write, no BVALID/RVALID after release.
- Write latency: last of AW/W handshake at edge N -> regs_o updated and BVALID high after edge N+1; wr_pulse_o high for cycle after N+1 only.
- Readies for next write reassert the cycle after B handshake; min write period 3 cycles with BREADY held high.
- Read latency: AR handshake at edge N -> RVALID high after edge N; min read period 2 cycles.
- Same-edge AR handshake and write commit to same register: read returns pre-write value.
- BVALID/RVALID, BRESP/RRESP/RDATA never change while VALID high and READY low.

## Test plan
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x0, 0x4, 0x8, 0xC (AW, W same cycle, BREADY=RREADY=1), read back each -> identical data, BRESP=RRESP=OKAY, wr_pulse_o bits 0..3 each pulse once.
- AWVALID 3 cycles before WVALID to 0x4, then reverse order to 0x8 -> AWREADY low during wait for W (WREADY low during wait for AW), writes land correctly.
- Reg1=0xabcd0001, write 0x12345678 WSTRB=4'b0011 -> reads 0xabcd5678.
- Write 0xFFFFFFFF to 0x10, read 0x10 -> BRESP=RRESP=2'b10, RDATA=0, regs_o unchanged, no wr_pulse_o.
- Hold BREADY low 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; concurrent read of 0x0 completes normally.
- Assert ARESET while BVALID high after write to 0x8 -> BVALID drops immediately, reg2 = RESET_VALUE, readies rise 1 cycle after release.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder for a small bank of 32-bit control registers.
// Write and read channels run as independent FSMs; register contents and write strobes go to downstream logic.
module axi_lite_reg_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_REGS           = 4,
    parameter logic [31:0] RESET_VALUE        = 32'h0
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]            regs_o,
    output logic [NUM_REGS-1:0]               wr_pulse_o
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned NBYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_A, WR_COMMIT, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t wr_state_q, wr_state_nxt;
    rd_state_t rd_state_q, rd_state_nxt;

    logic [NUM_REGS-1:0][DW-1:0] regs_q;
    logic [NUM_REGS-1:0]         wr_pulse_q;
    logic                        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic                        awready_nxt, wready_nxt, bvalid_nxt, arready_nxt, rvalid_nxt;
    logic [1:0]                  bresp_q, rresp_q;
    logic [DW-1:0]               rdata_q, rd_sel;
    logic [IDX_W-1:0]            aw_idx_q, ar_idx;
    logic [DW-1:0]               w_data_q;
    logic [NBYTES-1:0]           w_strb_q;
    logic                        aw_hs, w_hs, ar_hs, aw_latch, w_latch;
    logic                        wr_in_range, rd_in_range;
    logic                        unused_inputs;

    assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs       = S_AXI_AWVALID && awready_q;
    assign w_hs        = S_AXI_WVALID && wready_q;
    assign ar_hs       = S_AXI_ARVALID && arready_q;
    assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_in_range = 32'(aw_idx_q) < NUM_REGS;
    assign rd_in_range = 32'(ar_idx) < NUM_REGS;

    // Write FSM state register and registered channel controls
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_nxt;
            awready_q  <= awready_nxt;
            wready_q   <= wready_nxt;
            bvalid_q   <= bvalid_nxt;
        end
    end

    // Write next-state; readies/BVALID are decoded from the state being entered
    always_comb begin
        wr_state_nxt = wr_state_q;
        aw_latch     = 1'b0;
        w_latch      = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                aw_latch = aw_hs;
                w_latch  = w_hs;
                if (aw_hs && w_hs)  wr_state_nxt = WR_COMMIT;
                else if (aw_hs)     wr_state_nxt = WR_WAIT_W;
                else if (w_hs)      wr_state_nxt = WR_WAIT_A;
            end
            WR_WAIT_W: begin
                w_latch = w_hs;
                if (w_hs) wr_state_nxt = WR_COMMIT;
            end
            WR_WAIT_A: begin
                aw_latch = aw_hs;
                if (aw_hs) wr_state_nxt = WR_COMMIT;
            end
            WR_COMMIT: wr_state_nxt = WR_RESP;
            WR_RESP:   if (S_AXI_BREADY) wr_state_nxt = WR_IDLE;
            default:   wr_state_nxt = WR_IDLE;
        endcase
        awready_nxt = (wr_state_nxt == WR_IDLE) || (wr_state_nxt == WR_WAIT_A);
        wready_nxt  = (wr_state_nxt == WR_IDLE) || (wr_state_nxt == WR_WAIT_W);
        bvalid_nxt  = (wr_state_nxt == WR_RESP);
    end

    // Capture address/data and apply the strobed write on the commit cycle
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_q     <= {NUM_REGS{RESET_VALUE}};
            wr_pulse_q <= '0;
            bresp_q    <= RESP_OKAY;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (aw_latch) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_latch) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (wr_state_q == WR_COMMIT) begin
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (wr_in_range && (aw_idx_q == IDX_W'(k))) begin
                        wr_pulse_q[k] <= 1'b1;
                        for (int b = 0; b < NBYTES; b++) begin
                            if (w_strb_q[b]) regs_q[k][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux; out-of-range indices fall through to zero
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDX_W'(k)) rd_sel = regs_q[k];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_nxt;
            arready_q  <= arready_nxt;
            rvalid_q   <= rvalid_nxt;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs) rd_state_nxt = RD_DATA;
            RD_DATA: if (S_AXI_RREADY) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
        arready_nxt = (rd_state_nxt == RD_IDLE);
        rvalid_nxt  = (rd_state_nxt == RD_DATA);
    end

    // Read payload sampled from pre-edge register contents
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_sel;
            rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign regs_o        = regs_q;
    assign wr_pulse_o    = wr_pulse_q;

endmodule
